// File: rtl/abc_reg_arbiter_pkg.sv
// abc_arb_pkg: shared types and constants for the ABC register arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package abc_arb_pkg;

  // Controller states: two reset phases, then idle/response alternation.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    IDLE  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef logic [1:0] addr_t;

  localparam addr_t ADDR_R1  = 2'd0;
  localparam addr_t ADDR_R2  = 2'd1;
  localparam addr_t ADDR_CNT = 2'd2;

  // Default values loaded by the LOAD phase.
  localparam logic [31:0] R1_RST_DEF  = 32'h1234_5678;
  localparam logic [31:0] R2_RST_DEF  = 32'hdead_beef;
  localparam logic [31:0] CNT_RST_DEF = 32'h0000_0000;

  // Address 3 is the only illegal encoding.
  function automatic logic addr_legal(input addr_t a);
    return (a != 2'd3);
  endfunction

endpackage

// File: rtl/abc_reg_arbiter_if.sv
// abc_reg_arbiter_if: one requester's register-access channel.
// Latency: n/a (wires only); response follows acceptance by one cycle.
// Backpressure: master holds valid/write/addr/wdata until ready is seen.
// Signals: valid/ready request handshake, write (1 = write), addr, wdata;
//          rvalid one-cycle response pulse with rdata and err.
interface abc_reg_arbiter_if;
  import abc_arb_pkg::*;

  logic        valid;
  logic        ready;
  logic        write;
  addr_t       addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output valid, write, addr, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  valid, write, addr, wdata,
    output ready, rvalid, rdata, err
  );

endinterface

// File: rtl/abc_reg_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant with a last-grant pointer.
// Latency: combinational grant; pointer updates on the accept edge.
// Backpressure: a requester without grant simply keeps requesting.
// Ports: clk, rst (sync, active-high), req[1:0], accept, gnt[1:0] one-hot.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // 1 = requester 1 was granted most recently. Reset value makes
  // requester 0 win the first contention.
  logic last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/abc_reg_arbiter.sv
// abc_reg_arbiter: owns r1/r2/r_counter, round-robins access between m0/m1,
// and sequences the clear-then-load register reset.
// Latency: request accepted combinationally in IDLE; response one cycle later.
// Backpressure: ready low while busy or in RESP; requests wait, never dropped.
// Ports: clk, r (sync active-high reset), m0/m1 request channels (slave),
//        r1_q/r2_q/cnt_q register values, busy (high in CLEAR and LOAD).
// Option: ABC_ARB_ACCESS_COUNT_EN makes r_counter count accepted legal accesses.
module abc_reg_arbiter
  import abc_arb_pkg::*;
#(
  parameter int          CLR_CYCLES = 2,
  parameter logic [31:0] R1_RST     = R1_RST_DEF,
  parameter logic [31:0] R2_RST     = R2_RST_DEF,
  parameter logic [31:0] CNT_RST    = CNT_RST_DEF
) (
  input  logic                clk,
  input  logic                r,
  abc_reg_arbiter_if.slave    m0,
  abc_reg_arbiter_if.slave    m1,
  output logic [31:0]         r1_q,
  output logic [31:0]         r2_q,
  output logic [31:0]         cnt_q,
  output logic                busy
);

  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

  arb_state_t  state;
  logic [CW-1:0] clr_cnt;

  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        accept;

  // Selected request fields (from whichever requester holds the grant).
  logic        sel_write;
  addr_t       sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_legal;
  logic [31:0] rd_val;

  // Registered per-requester response.
  logic        rv0, rv1;
  logic [31:0] rd0, rd1;
  logic        er0, er1;

  // Requests only compete in IDLE and never while reset is asserted.
  assign req    = {m1.valid, m0.valid} & {2{(state == IDLE) && !r}};
  assign accept = |gnt;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (r),
    .req    (req),
    .accept (accept),
    .gnt    (gnt)
  );

  assign m0.ready = gnt[0];
  assign m1.ready = gnt[1];

  always_comb begin
    sel_write = gnt[1] ? m1.write : m0.write;
    sel_addr  = gnt[1] ? m1.addr  : m0.addr;
    sel_wdata = gnt[1] ? m1.wdata : m0.wdata;
    sel_legal = addr_legal(sel_addr);
    rd_val    = '0;
    case (sel_addr)
      ADDR_R1:  rd_val = r1_q;
      ADDR_R2:  rd_val = r2_q;
      ADDR_CNT: rd_val = cnt_q;
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      cnt_q   <= '0;
      rv0     <= 1'b0;
      rv1     <= 1'b0;
      rd0     <= '0;
      rd1     <= '0;
      er0     <= 1'b0;
      er1     <= 1'b0;
    end else begin
      // Response registers are single-cycle pulses by default.
      rv0 <= 1'b0;
      rv1 <= 1'b0;
      rd0 <= '0;
      rd1 <= '0;
      er0 <= 1'b0;
      er1 <= 1'b0;

      case (state)
        CLEAR: begin
          r1_q  <= '0;
          r2_q  <= '0;
          cnt_q <= '0;
          if (clr_cnt == CLR_LAST) begin
            state <= LOAD;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end

        LOAD: begin
          r1_q    <= R1_RST;
          r2_q    <= R2_RST;
          cnt_q   <= CNT_RST;
          clr_cnt <= '0;
          state   <= IDLE;
        end

        IDLE: begin
          if (accept) begin
            state <= RESP;
            rv0   <= gnt[0];
            rv1   <= gnt[1];
            // Reads capture the register as it is at the acceptance edge,
            // i.e. before any write or count update on that same edge.
            rd0   <= (gnt[0] && !sel_write) ? rd_val : '0;
            rd1   <= (gnt[1] && !sel_write) ? rd_val : '0;
            er0   <= gnt[0] && !sel_legal;
            er1   <= gnt[1] && !sel_legal;

            if (sel_write && sel_legal) begin
              case (sel_addr)
                ADDR_R1:  r1_q  <= sel_wdata;
                ADDR_R2:  r2_q  <= sel_wdata;
                ADDR_CNT: cnt_q <= sel_wdata;
                default:  ;
              endcase
            end

`ifdef ABC_ARB_ACCESS_COUNT_EN
            // A write to the counter wins over the increment on that edge.
            if (sel_legal && !(sel_write && (sel_addr == ADDR_CNT))) begin
              cnt_q <= cnt_q + 32'd1;
            end
`endif
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

  // Reset is sampled synchronously, but a response pending in the RESP cycle
  // must not be seen once reset is asserted, so r masks the pulse directly.
  assign m0.rvalid = rv0 & ~r;
  assign m1.rvalid = rv1 & ~r;
  assign m0.rdata  = r ? 32'd0 : rd0;
  assign m1.rdata  = r ? 32'd0 : rd1;
  assign m0.err    = er0 & ~r;
  assign m1.err    = er1 & ~r;

  assign busy = (state == CLEAR) || (state == LOAD);

endmodule

// File: tb/tb_abc_reg_arbiter.sv
// tb_abc_reg_arbiter: directed checks of reset sequencing, access, arbitration.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_abc_reg_arbiter;

  logic clk;
  logic r;
  logic [31:0] r1_q, r2_q, cnt_q;
  logic busy;

  int n_total;
  int n_pass;
  logic [31:0] exp_cnt;

  abc_reg_arbiter_if m0_if ();
  abc_reg_arbiter_if m1_if ();

  abc_reg_arbiter dut (
    .clk   (clk),
    .r     (r),
    .m0    (m0_if),
    .m1    (m1_if),
    .r1_q  (r1_q),
    .r2_q  (r2_q),
    .cnt_q (cnt_q),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit who, input logic v, input logic wr,
                       input logic [1:0] a, input logic [31:0] wd);
    if (who) begin
      m1_if.valid = v; m1_if.write = wr; m1_if.addr = a; m1_if.wdata = wd;
    end else begin
      m0_if.valid = v; m0_if.write = wr; m0_if.addr = a; m0_if.wdata = wd;
    end
  endtask

  // Counter model: only the count build advances it on legal accesses.
  task automatic count_legal();
`ifdef ABC_ARB_ACCESS_COUNT_EN
    exp_cnt = exp_cnt + 32'd1;
`endif
  endtask

  // One uncontended transaction starting in IDLE, ending back in IDLE.
  task automatic xact(input bit who, input logic wr, input logic [1:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd,
                      input logic exp_err, input string tag);
    drive(who, 1'b1, wr, a, wd);
    #1;
    chk({tag, "_ready"}, who ? m1_if.ready : m0_if.ready, 32'd1);
    chk({tag, "_other_ready"}, who ? m0_if.ready : m1_if.ready, 32'd0);
    step();
    drive(who, 1'b0, 1'b0, 2'd0, 32'd0);
    chk({tag, "_rvalid"}, who ? m1_if.rvalid : m0_if.rvalid, 32'd1);
    chk({tag, "_other_rvalid"}, who ? m0_if.rvalid : m1_if.rvalid, 32'd0);
    chk({tag, "_rdata"}, who ? m1_if.rdata : m0_if.rdata, exp_rd);
    chk({tag, "_err"}, who ? m1_if.err : m0_if.err, {31'd0, exp_err});
    step();
    chk({tag, "_rvalid_pulse"}, who ? m1_if.rvalid : m0_if.rvalid, 32'd0);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    exp_cnt = 32'd0;
    r = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);

    // ---- reset sequence ----
    step();
    chk("rst_busy", busy, 32'd1);
    chk("rst_r1", r1_q, 32'd0);
    chk("rst_m0_rvalid", m0_if.rvalid, 32'd0);
    chk("rst_m1_rdata", m1_if.rdata, 32'd0);
    r = 1'b0;
    #1;
    chk("clr1_busy", busy, 32'd1);
    chk("clr1_r2", r2_q, 32'd0);
    step();
    chk("clr2_busy", busy, 32'd1);
    chk("clr2_cnt", cnt_q, 32'd0);
    step();
    chk("load_busy", busy, 32'd1);
    step();
    chk("idle_busy", busy, 32'd0);
    chk("idle_r1", r1_q, 32'h1234_5678);
    chk("idle_r2", r2_q, 32'hdead_beef);
    chk("idle_cnt", cnt_q, 32'd0);

    // ---- single write then read ----
    xact(1'b0, 1'b1, 2'd1, 32'ha5a5_a5a5, 32'd0, 1'b0, "wr_r2");
    count_legal();
    chk("wr_r2_val", r2_q, 32'ha5a5_a5a5);
    chk("wr_r1_same", r1_q, 32'h1234_5678);
    xact(1'b0, 1'b0, 2'd1, 32'd0, 32'ha5a5_a5a5, 1'b0, "rd_r2");
    count_legal();
    chk("cnt_after_rw", cnt_q, exp_cnt);

    // ---- illegal address from m1 ----
    xact(1'b1, 1'b1, 2'd3, 32'hffff_ffff, 32'd0, 1'b1, "ill_wr");
    chk("ill_r1", r1_q, 32'h1234_5678);
    chk("ill_r2", r2_q, 32'ha5a5_a5a5);
    chk("ill_cnt", cnt_q, exp_cnt);
    xact(1'b1, 1'b0, 2'd3, 32'd0, 32'd0, 1'b1, "ill_rd");
    chk("ill_rd_cnt", cnt_q, exp_cnt);

    // ---- contention: last grant was m1, so m0, m1, m0, m1 ----
    drive(1'b0, 1'b1, 1'b0, 2'd0, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("cont%0d_m0_ready", i), m0_if.ready, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("cont%0d_m1_ready", i), m1_if.ready, (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
      chk($sformatf("cont%0d_resp_ready", i), {31'd0, m0_if.ready | m1_if.ready}, 32'd0);
      chk($sformatf("cont%0d_m0_rvalid", i), m0_if.rvalid, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("cont%0d_m1_rvalid", i), m1_if.rvalid, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("cont%0d_rdata", i), (i % 2 == 0) ? m0_if.rdata : m1_if.rdata, 32'h1234_5678);
      count_legal();
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    chk("cont_cnt", cnt_q, exp_cnt);

    // ---- counter write and wrap ----
    xact(1'b0, 1'b1, 2'd2, 32'hffff_ffff, 32'd0, 1'b0, "wr_cnt");
    exp_cnt = 32'hffff_ffff;
    chk("wr_cnt_val", cnt_q, exp_cnt);
    xact(1'b0, 1'b0, 2'd0, 32'd0, 32'h1234_5678, 1'b0, "wrap_rd_r1");
    count_legal();
    chk("wrap_cnt", cnt_q, exp_cnt);
    xact(1'b1, 1'b0, 2'd2, 32'd0, exp_cnt, 1'b0, "rd_cnt");
    count_legal();
    chk("rd_cnt_after", cnt_q, exp_cnt);

    // ---- reset during RESP drops the response; pending valid survives ----
    drive(1'b0, 1'b1, 1'b0, 2'd0, 32'd0);
    #1;
    chk("mid_ready", m0_if.ready, 32'd1);
    step();
    r = 1'b1;
    #1;
    chk("mid_rvalid_dropped", m0_if.rvalid, 32'd0);
    chk("mid_rdata_dropped", m0_if.rdata, 32'd0);
    step();
    r = 1'b0;
    #1;
    chk("mid_clr1_busy", busy, 32'd1);
    chk("mid_clr1_r1", r1_q, 32'd0);
    chk("mid_clr1_ready", m0_if.ready, 32'd0);
    chk("mid_clr1_rvalid", m0_if.rvalid, 32'd0);
    step();
    chk("mid_clr2_busy", busy, 32'd1);
    chk("mid_clr2_ready", m0_if.ready, 32'd0);
    step();
    chk("mid_load_busy", busy, 32'd1);
    chk("mid_load_ready", m0_if.ready, 32'd0);
    step();
    chk("mid_idle_busy", busy, 32'd0);
    chk("mid_idle_r1", r1_q, 32'h1234_5678);
    chk("mid_idle_r2", r2_q, 32'hdead_beef);
    chk("mid_idle_cnt", cnt_q, 32'd0);
    chk("mid_pending_ready", m0_if.ready, 32'd1);
    step();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    chk("mid_pending_rvalid", m0_if.rvalid, 32'd1);
    chk("mid_pending_rdata", m0_if.rdata, 32'h1234_5678);
    exp_cnt = 32'd0;
    count_legal();
    step();

    // ---- two more reads of r1: count build reaches 3 ----
    xact(1'b0, 1'b0, 2'd0, 32'd0, 32'h1234_5678, 1'b0, "cnt_rd2");
    count_legal();
    xact(1'b1, 1'b0, 2'd0, 32'd0, 32'h1234_5678, 1'b0, "cnt_rd3");
    count_legal();
    chk("cnt_three_reads", cnt_q, exp_cnt);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
